// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial subtractor: Diff = (A - B - Bin) mod 2^WIDTH, LSB first,
//   one bit per clock through a single full-adder cell. B is inverted and
//   the carry is seeded with ~Bin, so the final carry-out is ~borrow.
//
// Ports
//   clk   : rising-edge clock
//   rst   : synchronous, active-high reset
//   start : request an operation (accepted only while ready=1)
//   A, B  : minuend / subtrahend, sampled on accept
//   Bin   : borrow-in, sampled on accept
//   ready : high in IDLE
//   Diff  : result, updated only on completion
//   Bout  : borrow-out (A < B + Bin, unsigned), updated with Diff
//   done  : one-cycle pulse when Diff/Bout become valid
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             ready,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout,
    output logic             done
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    // Only the upper WIDTH-1 bits of the result shifter are kept: the
    // lowest position would only ever be shifted out on the final step.
    logic [WIDTH-2:0] r_sh;
    logic             carry;
    logic [CNT_W-1:0] cnt;

    logic             nb;
    logic             d;
    logic             carry_next;
    logic [WIDTH-1:0] r_next;

    // Full-adder cell on a + ~b + carry
    assign nb         = ~b_sh[0];
    assign d          = a_sh[0] ^ nb ^ carry;
    assign carry_next = (a_sh[0] & nb) | (nb & carry) | (a_sh[0] & carry);
    assign r_next     = {d, r_sh};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            r_sh  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            ready <= 1'b1;
            done  <= 1'b0;
            Diff  <= '0;
            Bout  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh  <= A;
                        b_sh  <= B;
                        carry <= ~Bin;
                        cnt   <= '0;
                        r_sh  <= '0;
                        ready <= 1'b0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    carry <= carry_next;
                    r_sh  <= r_next[WIDTH-1:1];
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    cnt   <= cnt + 1'b1;
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        Diff  <= r_next;
                        Bout  <= ~carry_next;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    // start is deliberately not looked at here
                    done  <= 1'b0;
                    ready <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b1;
                    done  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;
    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Bin;
    logic             ready;
    logic [WIDTH-1:0] Diff;
    logic             Bout;
    logic             done;

    int total = 0;
    int bad   = 0;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .Bin(Bin),
        .ready(ready), .Diff(Diff), .Bout(Bout), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer subtraction of the operands.
    function automatic logic [WIDTH:0] model(input int a, input int b, input int bin);
        int r;
        r = a - b - bin;
        model = {(r < 0) ? 1'b1 : 1'b0, WIDTH'(r & ((1 << WIDTH) - 1))};
    endfunction

    // Issue one operation (called with ready expected high), scramble the
    // inputs right after accept, and check latency, result and handshake.
    task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic bin, input string tag);
        int n;
        logic [WIDTH:0] exp;
        n = 0;
        while (!ready && n < 20) begin tick(); n++; end
        check({tag, "_ready_before"}, ready, 1);
        exp = model(a, b, bin);
        A = a; B = b; Bin = bin; start = 1'b1;
        tick();
        start = 1'b0;
        A = WIDTH'($urandom); B = WIDTH'($urandom); Bin = 1'($urandom);
        check({tag, "_busy"}, ready, 0);
        n = 0;
        while (!done && n < 20) begin tick(); n++; end
        check({tag, "_latency"}, n, WIDTH);
        check({tag, "_done"}, done, 1);
        check({tag, "_diff"}, Diff, exp[WIDTH-1:0]);
        check({tag, "_bout"}, Bout, exp[WIDTH]);
        tick();
        check({tag, "_done_pulse"}, done, 0);
        check({tag, "_ready_back"}, ready, 1);
    endtask

    initial begin
        int n;
        int seen;
        rst = 1'b1; start = 1'b0; A = '0; B = '0; Bin = 1'b0;
        tick(); tick();
        rst = 1'b0;
        check("rst_ready", ready, 1);
        check("rst_done", done, 0);
        check("rst_diff", Diff, 0);
        check("rst_bout", Bout, 0);

        // Idle hold with start low
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle_hold", {ready, done, Bout, Diff}, {1'b1, 1'b0, 1'b0, 4'b0000});
        end

        // Directed cases
        do_op(4'b0101, 4'b0011, 1'b0, "d_5m3");
        check("d_5m3_lit", {Bout, Diff}, 5'b0_0010);
        do_op(4'b0011, 4'b0101, 1'b0, "d_3m5");
        check("d_3m5_lit", {Bout, Diff}, 5'b1_1110);
        do_op(4'b0000, 4'b0000, 1'b1, "d_0m0b");
        check("d_0m0b_lit", {Bout, Diff}, 5'b1_1111);
        do_op(4'b1111, 4'b1111, 1'b1, "d_fmfb");
        check("d_fmfb_lit", {Bout, Diff}, 5'b1_1111);
        do_op(4'b1010, 4'b0101, 1'b1, "d_amb5");
        check("d_amb5_lit", {Bout, Diff}, 5'b0_0100);

        // Second start during SHIFT is ignored, not queued
        A = 4'b1000; B = 4'b0001; Bin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        A = 4'b0000; B = 4'b1111; start = 1'b1;
        tick();
        start = 1'b0;
        n = 2;
        while (!done && n < 20) begin tick(); n++; end
        check("ign_latency", n, WIDTH);
        check("ign_diff", Diff, 4'b0111);
        check("ign_bout", Bout, 0);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done) seen++;
        end
        check("ign_single_done", seen, 0);
        check("ign_hold_diff", Diff, 4'b0111);

        // Reset mid-operation discards the operation
        A = 4'b1100; B = 4'b0100; Bin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_ready", ready, 1);
        check("mid_rst_diff", Diff, 0);
        check("mid_rst_bout", Bout, 0);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (done) seen++;
            tick();
        end
        check("mid_rst_no_done", seen, 0);

        // Exhaustive back-to-back
        for (int i = 0; i < 512; i++)
            do_op(WIDTH'(i >> 5), WIDTH'(i >> 1), 1'(i), "exh");

        // Random operands with random idle gaps; Diff must hold while idle
        for (int i = 0; i < 40; i++) begin
            logic [WIDTH:0] held;
            held = {Bout, Diff};
            n = $urandom_range(0, 3);
            for (int j = 0; j < n; j++) begin
                tick();
                check("rnd_hold", {Bout, Diff}, held);
            end
            do_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), "rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
